iobuf_bank_ctrl: RTL
====================

// Module: iobuf_bank_ctrl
// PURPOSE
//  Parametrised controller for a bank of WIDTH bidirectional IOBUF pads. It replaces the single shared tristate
//  with per-bit output enables and adds safe bus turnaround on direction changes. It synchronises pad input and
//  reports changes on input-mode bits as valid pulses. Sits between core logic and the per-bit IOBUF primitives.
// PARAMETERS
//  WIDTH        8  number of pads in the bank (1..64)
//  SYNC_STAGES  2  input synchroniser depth on pad_O (2..4)
//  TURN_CYCLES  2  hi-Z cycles inserted before any bit newly starts driving (0..15)
// PORTS
//  CLK        in   1      sole clock
//  nRST       in   1      asynchronous reset, active low
//  cmd_valid  in   1      drive-command request
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
//  cmd_data   in   WIDTH  value to drive on output-mode bits
//  cmd_oe     in   WIDTH  per-bit output enable, 1 = drive
//  rd_valid   out  1      1-cycle pulse: synced input-mode bits changed
//  rd_data    out  WIDTH  synchronised pad value (all bits)
//  pad_I      out  WIDTH  to IOBUF I (drive value)
//  pad_T      out  WIDTH  to IOBUF T, 1 = hi-Z
//  pad_O      in   WIDTH  from IOBUF O (asynchronous pad value)
// BEHAVIOUR
//  Reset (nRST low, async): pad_T all 1, pad_I 0, oe_q 0, cmd_ready 1, rd_valid 0, rd_data 0, sync regs 0,
//   state IDLE, prime counter cleared. Reset mid-turnaround discards the pending command.
//  pad_T = ~oe_q; pad_I = data_q (registered, no combinational path from cmd_*).
//  FSM IDLE: cmd_ready=1. On accept: rise = cmd_oe & ~oe_q.
//   - rise==0 or TURN_CYCLES==0: oe_q<=cmd_oe, data_q<=cmd_data next edge (latency 1), stay IDLE.
//   - else: immediately oe_q<=oe_q & cmd_oe (falling bits release at once, kept bits take new data),
//     latch cmd into pend_*, cnt<=TURN_CYCLES-1, go TURN.
//  FSM TURN: cmd_ready=0; rising bits held hi-Z. cnt==0 -> oe_q<=pend_oe, data_q<=pend_data, go IDLE;
//   else cnt--. A rising bit drives exactly TURN_CYCLES+1 cycles after accept; next accept is at the earliest on that cycle.
//  cmd_oe identical to oe_q: data-only update, latency 1, no turnaround.
//  Input path: pad_O -> SYNC_STAGES flops -> s; rd_data<=s each cycle; prev<=s.
//   rd_valid<=|((s^prev) & ~oe_q) && primed. Output-mode bits never raise rd_valid.
//   primed sets after SYNC_STAGES+1 cycles out of reset (suppresses spurious reset-release change).
//  A bit that toggles in the same cycle oe_q changes is masked with the oe_q value at that compare.
//  Input path is independent of FSM; cmd accept and rd_valid may occur in the same cycle.
//  Widths: cnt is 4 bits; all data vectors WIDTH bits, no arithmetic on data.
// TESTING
//  1 Reset: hold nRST low 3 cycles, pad_O=0xFF -> pad_T=0xFF, cmd_ready=1, rd_valid stays 0 through priming.
//  2 WIDTH=8,TURN=2: oe 0x00->0x0F,data 0xA5 -> pad_T=0xFF for 2 cycles after accept, then pad_T=0xF0,pad_I=0x05/0xA5 low nibble.
//  3 From oe=0x0F issue oe=0xF0 -> bits 3:0 hi-Z next cycle, bits 7:4 drive 3 cycles after accept, cmd_ready low 2 cycles.
//  4 oe=0x0F, pad_O low nibble toggles 0x0->0x5 -> no rd_valid; high nibble 0x0->0x3 -> rd_valid once, rd_data[7:4]=3 after SYNC_STAGES+1.
//  5 Assert nRST low during TURN -> all pads hi-Z at once; after release, pending command never applied.
//  6 TURN_CYCLES=0: oe 0x00->0xFF data 0x3C -> pad_T=0x00, pad_I=0x3C one cycle after accept.

Source files
------------

// File: rtl/iobuf_bank_ctrl_if.sv
// Bundle of command, read-back and per-bit IOBUF pad signals for one pad bank.
// No latency of its own; carries the valid/ready command handshake and the rd_valid pulse.
// Backpressure: cmd_ready low holds the command source until the bank controller can accept.
interface iobuf_bank_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cmd_oe;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] pad_I;
  logic [WIDTH-1:0] pad_T;
  logic [WIDTH-1:0] pad_O;

  // Core side plus the pad primitives' O output: issues commands, observes the bank.
  modport master (
    output cmd_valid, cmd_data, cmd_oe, pad_O,
    input  cmd_ready, rd_valid, rd_data, pad_I, pad_T
  );

  // Bank controller side.
  modport slave (
    input  cmd_valid, cmd_data, cmd_oe, pad_O,
    output cmd_ready, rd_valid, rd_data, pad_I, pad_T
  );
endinterface

// File: rtl/iobuf_bank_ctrl.sv
// Per-bit output-enable controller for a bank of IOBUF pads with safe turnaround and synced read-back.
// Latency: 1 cycle for commands without newly driving bits, TURN_CYCLES+1 otherwise; rd_valid SYNC_STAGES+1 after pad_O.
// Backpressure: cmd_ready drops while a turnaround is in progress; the read-back path never stalls.
module iobuf_bank_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  iobuf_bank_ctrl_if.slave   bus
);

  typedef enum logic {S_IDLE, S_TURN} state_t;

  // Counter reload: TURN_CYCLES-1 extra hold cycles after the accept edge.
  localparam logic [3:0] CNT_INIT = 4'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  // Read-back compares are ignored until the synchroniser and prev register hold real pad data.
  localparam logic [2:0] PRIME_N  = 3'(SYNC_STAGES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_cmd_ready;
  logic             w_acc;
  logic             w_turn;
  logic [WIDTH-1:0] w_rise;

  logic [WIDTH-1:0] r_oe_q;
  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] r_pend_oe;
  logic [WIDTH-1:0] r_pend_data;
  logic [3:0]       r_cnt;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [2:0]       r_prime_cnt;
  logic             w_primed;

  assign w_acc  = bus.cmd_valid & w_cmd_ready;
  // Bits that go from hi-Z to driving need a turnaround; releasing bits never do.
  assign w_rise = bus.cmd_oe & ~r_oe_q;
  assign w_turn = w_acc && (|w_rise) && (TURN_CYCLES != 0);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: enter TURN on an accept with rising bits, leave when the counter expires.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_turn) w_state_nxt = S_TURN;
    end else begin
      if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
    end
  end

  // Outputs of the FSM: only IDLE takes new commands.
  always_comb begin
    w_cmd_ready = 1'b0;
    if (r_state == S_IDLE) w_cmd_ready = 1'b1;
  end

  // Drive registers: immediate apply, or release falling bits now and hold the full command pending.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_oe_q      <= '0;
      r_data_q    <= '0;
      r_pend_oe   <= '0;
      r_pend_data <= '0;
      r_cnt       <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_acc) begin
        r_data_q <= bus.cmd_data;
        if (w_turn) begin
          r_oe_q      <= r_oe_q & bus.cmd_oe;
          r_pend_oe   <= bus.cmd_oe;
          r_pend_data <= bus.cmd_data;
          r_cnt       <= CNT_INIT;
        end else begin
          r_oe_q <= bus.cmd_oe;
        end
      end
    end else begin
      if (r_cnt == 4'd0) begin
        r_oe_q   <= r_pend_oe;
        r_data_q <= r_pend_data;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Pad input synchroniser chain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.pad_O;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime_cnt == PRIME_N);

  // Priming counter: saturates once the first real sample has reached r_prev.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                    r_prime_cnt <= 3'd0;
    else if (r_prime_cnt != PRIME_N) r_prime_cnt <= r_prime_cnt + 3'd1;
  end

  // Read-back: report changes on input-mode bits only, masked by the current output enables.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_prev     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_prev     <= w_s;
      r_rd_data  <= w_s;
      r_rd_valid <= (|((w_s ^ r_prev) & ~r_oe_q)) && w_primed;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.pad_T     = ~r_oe_q;
  assign bus.pad_I     = r_data_q;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;

endmodule
